// File: rtl/bemicrocv_led_sched.sv
// LED pattern scheduler for the BeMicro CV: debounced Tact1 cycles four patterns stepped by a tick divider.
// Optional PWM dimming of lit LEDs is enabled by defining BEMICROCV_LED_SCHED_PWM_DIM_EN.
module bemicrocv_led_sched #(
    parameter int   W_CNT      = 23,
    parameter int   DEB_CYCLES = 240000,
    parameter logic LED_ON     = 1'b0,
    parameter logic TACT_ON    = 1'b0,
    parameter int   DIM_LEVEL  = 4
) (
    input  logic       CLK_24MHz,
    input  logic       RESET_N,
    input  logic       Tact1,
    output logic [7:0] LED,
    output logic [1:0] mode,
    output logic       tick
);

    localparam logic LED_OFF  = ~LED_ON;
    localparam logic TACT_OFF = ~TACT_ON;
    localparam int   W_DEB    = $clog2(DEB_CYCLES + 1);
    localparam logic [W_DEB-1:0] DEB_LAST = W_DEB'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        CHASE  = 2'd0,
        BOUNCE = 2'd1,
        BLINK  = 2'd2,
        COUNT  = 2'd3
    } mode_t;

    generate
        if (DEB_CYCLES < 1 || DIM_LEVEL < 0 || DIM_LEVEL > 16) begin : g_bad_param
            $error("bemicrocv_led_sched: DEB_CYCLES must be >= 1 and DIM_LEVEL within 0..16");
        end
    endgenerate

    function automatic logic [7:0] led_pins(input logic [7:0] lit);
        logic [7:0] pins;
        for (int i = 0; i < 8; i++) begin
            pins[i] = lit[i] ? LED_ON : LED_OFF;
        end
        return pins;
    endfunction

    logic [1:0]       sync_r;
    logic             deb_r;
    logic [W_DEB-1:0] deb_cnt_r;
    logic             press_r;
    logic [W_CNT-1:0] cnt_r;
    logic             tick_r;
    mode_t            mode_r;
    logic [7:0]       step_r;
    logic             dir_r;
    logic [7:0]       led_r;

    logic             deb_nxt_s;
    logic [W_DEB-1:0] deb_cnt_nxt_s;
    logic             press_nxt_s;
    logic [W_CNT-1:0] cnt_nxt_s;
    logic             tick_nxt_s;
    mode_t            mode_nxt_s;
    logic [7:0]       step_nxt_s;
    logic             dir_nxt_s;
    logic [7:0]       lit_s;
    logic [7:0]       led_nxt_s;

    // Debounce: a new level is accepted only after DEB_CYCLES consecutive differing samples
    always_comb begin
        deb_nxt_s     = deb_r;
        deb_cnt_nxt_s = '0;
        if (sync_r[1] != deb_r) begin
            if (deb_cnt_r == DEB_LAST) begin
                deb_nxt_s     = sync_r[1];
                deb_cnt_nxt_s = '0;
            end else begin
                deb_nxt_s     = deb_r;
                deb_cnt_nxt_s = deb_cnt_r + W_DEB'(1);
            end
        end else begin
            deb_nxt_s     = deb_r;
            deb_cnt_nxt_s = '0;
        end
        press_nxt_s = (deb_nxt_s == TACT_ON) && (deb_r != TACT_ON);
    end

    // Step divider; tick is precomputed so the output is a plain register and a press masks it
    always_comb begin
        cnt_nxt_s = '1;
        if (press_r || (cnt_r == '0)) begin
            cnt_nxt_s = '1;
        end else begin
            cnt_nxt_s = cnt_r - W_CNT'(1);
        end
        tick_nxt_s = (cnt_nxt_s == '0) && !press_nxt_s;
    end

    // Mode FSM next state: each press advances the mode
    always_comb begin
        mode_nxt_s = mode_r;
        case (mode_r)
            CHASE:   mode_nxt_s = press_r ? BOUNCE : CHASE;
            BOUNCE:  mode_nxt_s = press_r ? BLINK  : BOUNCE;
            BLINK:   mode_nxt_s = press_r ? COUNT  : BLINK;
            COUNT:   mode_nxt_s = press_r ? CHASE  : COUNT;
            default: mode_nxt_s = CHASE;
        endcase
    end

    // Step and bounce direction; dir_r = 1 means moving toward bit 0
    always_comb begin
        step_nxt_s = step_r;
        dir_nxt_s  = dir_r;
        if (press_r) begin
            step_nxt_s = 8'd0;
            dir_nxt_s  = 1'b0;
        end else if (tick_r) begin
            case (mode_r)
                BOUNCE: begin
                    if (!dir_r) begin
                        step_nxt_s = step_r + 8'd1;
                        dir_nxt_s  = (step_r == 8'd6);
                    end else begin
                        step_nxt_s = step_r - 8'd1;
                        dir_nxt_s  = (step_r != 8'd1);
                    end
                end
                default: begin
                    step_nxt_s = step_r + 8'd1;
                    dir_nxt_s  = dir_r;
                end
            endcase
        end else begin
            step_nxt_s = step_r;
            dir_nxt_s  = dir_r;
        end
    end

    // FSM output decode: lit pattern of the upcoming state so a press shows step 0 immediately
    always_comb begin
        lit_s = 8'h00;
        case (mode_nxt_s)
            CHASE, BOUNCE: lit_s = 8'd1 << step_nxt_s[2:0];
            BLINK:         lit_s = step_nxt_s[0] ? 8'h00 : 8'hFF;
            COUNT:         lit_s = step_nxt_s;
            default:       lit_s = 8'h00;
        endcase
    end

`ifdef BEMICROCV_LED_SCHED_PWM_DIM_EN
    logic [3:0] pwm_r;

    // Free-running dimming slot counter
    always_ff @(posedge CLK_24MHz) begin
        if (!RESET_N) begin
            pwm_r <= 4'd0;
        end else begin
            pwm_r <= pwm_r + 4'd1;
        end
    end

    // Lit bits only light during the first DIM_LEVEL slots of every 16
    always_comb begin
        if ({1'b0, pwm_r} < 5'(DIM_LEVEL)) begin
            led_nxt_s = led_pins(lit_s);
        end else begin
            led_nxt_s = led_pins(8'h00);
        end
    end
`else
    // Lit bits are steadily on
    always_comb begin
        led_nxt_s = led_pins(lit_s);
    end
`endif

    // Input synchronizer and debounce state
    always_ff @(posedge CLK_24MHz) begin
        if (!RESET_N) begin
            sync_r    <= {2{TACT_OFF}};
            deb_r     <= TACT_OFF;
            deb_cnt_r <= '0;
            press_r   <= 1'b0;
        end else begin
            sync_r    <= {sync_r[0], Tact1};
            deb_r     <= deb_nxt_s;
            deb_cnt_r <= deb_cnt_nxt_s;
            press_r   <= press_nxt_s;
        end
    end

    // Tick divider state
    always_ff @(posedge CLK_24MHz) begin
        if (!RESET_N) begin
            cnt_r  <= '1;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= tick_nxt_s;
        end
    end

    // Mode FSM state register
    always_ff @(posedge CLK_24MHz) begin
        if (!RESET_N) begin
            mode_r <= CHASE;
        end else begin
            mode_r <= mode_nxt_s;
        end
    end

    // Pattern step and LED pin registers
    always_ff @(posedge CLK_24MHz) begin
        if (!RESET_N) begin
            step_r <= 8'd0;
            dir_r  <= 1'b0;
            led_r  <= {8{LED_OFF}};
        end else begin
            step_r <= step_nxt_s;
            dir_r  <= dir_nxt_s;
            led_r  <= led_nxt_s;
        end
    end

    assign LED  = led_r;
    assign mode = mode_r;
    assign tick = tick_r;

endmodule

// File: tb/tb_bemicrocv_led_sched.sv
// Randomized bench for bemicrocv_led_sched against a pattern-level reference model.
// Build with BEMICROCV_LED_SCHED_PWM_DIM_EN to also model dimming.
module tb_bemicrocv_led_sched;

    logic       clk;
    logic       RESET_N;
    logic       Tact1;
    logic [7:0] LED;
    logic [1:0] mode;
    logic       tick;

    int n_chk;
    int n_fail;

    bemicrocv_led_sched #(
        .W_CNT      (4),
        .DEB_CYCLES (4),
        .LED_ON     (1'b0),
        .TACT_ON    (1'b0),
        .DIM_LEVEL  (4)
    ) dut (
        .CLK_24MHz (clk),
        .RESET_N   (RESET_N),
        .Tact1     (Tact1),
        .LED       (LED),
        .mode      (mode),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode, ticks since mode entry, cycles since divider reload
    bit         m_hist[$];
    bit         m_deb;
    bit         m_press;
    bit         m_tick;
    int         m_mode;
    int         m_k;
    int         m_q;
    int         m_e;
    logic [7:0] exp_led;

    function automatic logic [7:0] lit_of(input int md, input int k);
        int p;
        case (md)
            0:       return 8'd1 << (k % 8);
            1: begin
                p = k % 14;
                return 8'd1 << ((p <= 7) ? p : 14 - p);
            end
            2:       return ((k % 2) == 0) ? 8'hFF : 8'h00;
            default: return 8'(k % 256);
        endcase
    endfunction

    task automatic model_edge(input bit t, input bit r);
        int  l;
        bit  diff;
        logic [7:0] lit;
        if (!r) begin
            m_hist.delete();
            for (int i = 0; i < 5; i++) m_hist.push_back(1'b1);
            m_deb = 1'b1; m_press = 1'b0; m_tick = 1'b0;
            m_mode = 0; m_k = 0; m_q = 0; m_e = 0;
            exp_led = 8'hFF;
        end else begin
            m_e++;
            if (m_press) begin
                m_mode = (m_mode + 1) % 4;
                m_k = 0;
                m_q = 0;
            end else begin
                if (m_tick) m_k++;
                m_q++;
            end
            m_hist.push_back(t);
            l = m_hist.size();
            // synchronized sample lags the pin by two clocks; need four in a row against the held level
            diff = 1'b1;
            for (int i = 3; i <= 6; i++) if (m_hist[l - i] == m_deb) diff = 1'b0;
            m_press = diff && m_deb;
            if (diff) m_deb = ~m_deb;
            if (l > 10) void'(m_hist.pop_front());
            m_tick = ((m_q % 16) == 15) && !m_press;
            lit = lit_of(m_mode, m_k);
`ifdef BEMICROCV_LED_SCHED_PWM_DIM_EN
            if (((m_e - 1) % 16) >= 4) lit = 8'h00;
`endif
            exp_led = ~lit;
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input bit t, input bit r);
        Tact1   = t;
        RESET_N = r;
        @(posedge clk);
        @(negedge clk);
        model_edge(t, r);
        check_val("led",  32'(LED),  32'(exp_led));
        check_val("mode", 32'(mode), 32'(m_mode));
        check_val("tick", 32'(tick), 32'(m_tick));
    endtask

    task automatic press_btn();
        repeat (8) cyc(1'b0, 1'b1);
        repeat (8) cyc(1'b1, 1'b1);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        Tact1   = 1'b1;
        RESET_N = 1'b0;
        @(negedge clk);

        repeat (3) cyc(1'b1, 1'b0);
        repeat (140) cyc(1'b1, 1'b1);

        // clean held press into BOUNCE, then a full bounce period
        repeat (20) cyc(1'b0, 1'b1);
        repeat (20) cyc(1'b1, 1'b1);
        repeat (14 * 16 + 20) cyc(1'b1, 1'b1);

        // short glitches must not count, a long hold must
        repeat (5) begin
            repeat (2) cyc(1'b0, 1'b1);
            repeat (2) cyc(1'b1, 1'b1);
        end
        repeat (6) cyc(1'b0, 1'b1);
        repeat (20) cyc(1'b1, 1'b1);

        // sweep the press across every divider phase, including the tick cycle
        for (int ph = 0; ph < 16; ph++) begin
            repeat (ph) cyc(1'b1, 1'b1);
            repeat (6) cyc(1'b0, 1'b1);
            repeat (16) cyc(1'b1, 1'b1);
        end

        // BLINK, then COUNT through a full 256-tick wrap
        for (int i = 0; i < 4 && m_mode != 2; i++) press_btn();
        repeat (100) cyc(1'b1, 1'b1);
        press_btn();
        repeat (256 * 16 + 40) cyc(1'b1, 1'b1);

        // reset in the middle of COUNT
        cyc(1'b1, 1'b0);
        repeat (30) cyc(1'b1, 1'b1);

        // randomized button activity with occasional resets
        repeat (80) begin
            if ($urandom_range(0, 49) == 0) begin
                cyc(1'b1, 1'b0);
            end else if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 8)) cyc(1'b0, 1'b1);
            end else begin
                repeat ($urandom_range(1, 40)) cyc(1'b1, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bemicrocv_led_sched.md
Name: bemicrocv_led_sched

Overview:
Pattern scheduler for the eight active-low user LEDs (D4..D11) on the BeMicro CV board.
- Derives a step tick from CLK_24MHz with a reloading down-counter.
- Debounces the active-low Tact1 push-button; each press advances a 4-mode pattern state machine.
- Drives the LED bank with the selected pattern.
- Sits at top level between the board pins and the LED outputs, replacing per-LED hard-coded sequencing.

Parameters:
W_CNT, 23, width of tick down-counter; tick period = 2^W_CNT cycles (~0.35 s at 24 MHz).
DEB_CYCLES, 240000, consecutive stable cycles required to accept a new button level (10 ms).
LED_ON, 1'b0, pin level that lights an LED (LED_OFF is its inverse).
TACT_ON, 1'b0, pin level of a pressed button.
DIM_LEVEL, 4, PWM on-slots out of 16 (used only with PWM_DIM_EN).

Ports:
CLK_24MHz  in   1  board clock, all logic on rising edge.
RESET_N    in   1  synchronous, active-low reset.
Tact1      in   1  raw push-button, asynchronous, TACT_ON = pressed.
LED        out  8  LED pins, bit0 = D4 ... bit7 = D11, active-low (LED_ON lights).
mode       out  2  current mode: 0 CHASE, 1 BOUNCE, 2 BLINK, 3 COUNT.
tick       out  1  one-cycle pulse at each pattern step.

Behaviour:
- Reset (RESET_N low at a clock edge):
  - LED = 8'hFF (all off); mode = CHASE; step = 0; dir = up.
  - tick = 0; counter = all-ones.
  - Synchronizer and debounced level = TACT_OFF; debounce counter = 0.
  - Reset mid-pattern aborts immediately; no residual LED state.
- Input path:
  - 2-flop synchronizer on Tact1.
  - Debounce counter clears whenever the synchronized level equals the debounced level, otherwise increments.
  - At DEB_CYCLES the debounced level takes the new value and the counter clears.
  - press = one-cycle pulse on a debounced OFF->ON transition.
  - Holding the button gives exactly one press; release generates nothing.
- Tick:
  - Counter decrements each cycle; at zero it reloads all-ones and tick = 1 for that cycle.
  - Counter arithmetic is W_CNT bits, wrap by reload only.
- Mode FSM on press: CHASE -> BOUNCE -> BLINK -> COUNT -> CHASE.
  - A press also reloads the counter to all-ones and sets step = 0, dir = up.
  - A press and a tick in the same cycle: press wins and the tick pulse is suppressed.
- Patterns (lit bits shown; pin = lit ? LED_ON : LED_OFF):
  - CHASE: only bit step[2:0] lit; step increments per tick, 7 wraps to 0.
  - BOUNCE: only bit pos lit; pos runs 0,1..7,6..1,0,1..., so the period is 14 ticks.
    - dir flips to down on reaching 7 and flips to up on reaching 0.
  - BLINK: step0 all lit; each tick toggles all lit / all dark.
  - COUNT: lit = 8-bit step value; +1 per tick, 255 wraps to 0.
- Latency:
  - LED is registered and updates the cycle after a tick, or the cycle after a press.
  - After a press, the step-0 pattern of the new mode appears one cycle later without waiting for a tick.
  - Step-0 patterns: CHASE 8'hFE, BOUNCE 8'hFE, BLINK 8'h00, COUNT 8'hFF (pin levels).
- mode output changes the cycle after press.

Optional Feature:
BEMICROCV_LED_SCHED_PWM_DIM_EN
- Defined:
  - A 4-bit free-running PWM counter (reset 0) gates lit LEDs.
  - A lit bit drives LED_ON only while pwm < DIM_LEVEL, else LED_OFF.
  - Dark bits are always LED_OFF.
  - Pattern sequencing and timing are unchanged.
- Undefined: no PWM counter; lit LEDs are steady LED_ON.

Test Plan (W_CNT=4, DEB_CYCLES=4):
- Release reset with Tact1=1 -> LED=8'hFE (CHASE step 0) after the first pattern update; 8 ticks (16 cycles each) -> LED walks FE,FD,FB,...,7F,FE; tick pulses exactly every 16 cycles.
- One clean press (Tact1=0 held for 20 cycles) -> exactly one mode change to 1, LED=8'hFE next cycle; 14 ticks -> position sequence 0..7..0; positions 7 and 0 each held one tick only.
- Bounce glitches (Tact1 low 2 cycles, high 2, repeated 5x) -> no press, mode unchanged; then hold low 6 cycles -> one press.
- Four presses from CHASE -> modes 1,2,3,0; in COUNT run 256 ticks -> LED shows ~step, 8'hFF (0) after wrap; BLINK alternates 00/FF.
- Press timed in the tick cycle -> tick stays 0 that cycle, counter reloads, next tick 16 cycles later; RESET_N low mid-COUNT -> next cycle LED=8'hFF, mode=0.
- With PWM_DIM_EN, DIM_LEVEL=4 -> each lit LED low for 4 of every 16 cycles; dark LEDs stay high.
